// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer with the architectural HI/LO pair.
// Define MULDIV_DIV0_EXC_EN to trap div/divu by zero instead of computing it.
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [5:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hilo_rd_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
`ifdef MULDIV_DIV0_EXC_EN
  ,
  output logic             div0_exc_o
`endif
);

  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               op_div;
  logic               neg_lo;
  logic               neg_hi;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
    return n ? ('0 - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? ('0 - v) : v;
  endfunction

  logic is_mul, is_div, is_sgn, is_hilo, start_req, start_ok, idle_ok;
  logic signed [WIDTH-1:0] rs_s, rt_s;
  logic [WIDTH-1:0] a_op, b_op;

  assign rs_s    = $signed(rs_i);
  assign rt_s    = $signed(rt_i);
  assign is_mul  = (alu_ctrl_i == OP_MULT) || (alu_ctrl_i == OP_MULTU);
  assign is_div  = (alu_ctrl_i == OP_DIV)  || (alu_ctrl_i == OP_DIVU);
  assign is_sgn  = (alu_ctrl_i == OP_MULT) || (alu_ctrl_i == OP_DIV);
  assign is_hilo = (alu_ctrl_i >= OP_MFHI) && (alu_ctrl_i <= OP_MTLO);
  assign idle_ok = (state == IDLE) && valid_i && !flush_i;
  assign start_req = idle_ok && (is_mul || is_div);
  assign a_op    = is_sgn ? abs_val(rs_s) : rs_i;
  assign b_op    = is_sgn ? abs_val(rt_s) : rt_i;

`ifdef MULDIV_DIV0_EXC_EN
  logic div0_req;
  assign div0_req = start_req && is_div && (rt_i == '0);
  assign start_ok = start_req && !div0_req;
`else
  assign start_ok = start_req;
`endif

  // Working remainder is one bit wider so the trial subtract never overflows.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             q_bit;
  assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opb : '0)};
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign q_bit     = ~div_diff[WIDTH];

  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_quo, fin_rem;
  assign fin_prod = neg_2w(neg_lo, prod);
  assign fin_quo  = neg_w(neg_lo, quo);
  assign fin_rem  = neg_w(neg_hi, rem);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (cnt == CNT_W'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)
        cnt <= CNT_W'(WIDTH);
      else if (state == RUN)
        cnt <= cnt - CNT_W'(1);
      if (state == FIN && !flush_i) begin
        hi_o <= op_div ? fin_rem : fin_prod[2*WIDTH-1:WIDTH];
        lo_o <= op_div ? fin_quo : fin_prod[WIDTH-1:0];
      end else if (idle_ok && alu_ctrl_i == OP_MTHI) begin
        hi_o <= rs_i;
      end else if (idle_ok && alu_ctrl_i == OP_MTLO) begin
        lo_o <= rs_i;
      end
    end
  end

`ifdef MULDIV_DIV0_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) div0_exc_o <= 1'b0;
    else     div0_exc_o <= div0_req;
  end
`endif

  // Datapath: operand latch on start, one shift-add or restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      op_div <= is_div;
      neg_lo <= is_sgn && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
      neg_hi <= is_sgn && (is_div ? rs_i[WIDTH-1] : (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]));
      prod   <= {{WIDTH{1'b0}}, b_op};
      opb    <= is_div ? b_op : a_op;
      quo    <= a_op;
      rem    <= '0;
    end else if (state == RUN) begin
      if (op_div) begin
        rem <= q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], q_bit};
      end else begin
        prod <= {mul_sum, prod[WIDTH-1:1]};
      end
    end
  end

  assign busy_o    = (state == RUN) || (state == FIN);
  assign done_o    = (state == FIN) && !flush_i;
  assign stall_o   = valid_i && busy_o && (is_hilo || is_mul || is_div);
  assign hilo_rd_o = (alu_ctrl_i == OP_MFHI) ? hi_o :
                     (alu_ctrl_i == OP_MFLO) ? lo_o : '0;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed self-checking bench for muldiv_hilo_ctrl (honours MULDIV_DIV0_EXC_EN).
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i;
  logic [5:0]  alu_ctrl_i;
  logic [31:0] rs_i, rt_i;
  logic [31:0] hilo_rd_o, hi_o, lo_o;
  logic        stall_o, busy_o, done_o;
`ifdef MULDIV_DIV0_EXC_EN
  logic        div0_exc_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  muldiv_hilo_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .alu_ctrl_i(alu_ctrl_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i), .hilo_rd_o(hilo_rd_o),
    .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .hi_o(hi_o), .lo_o(lo_o)
`ifdef MULDIV_DIV0_EXC_EN
    , .div0_exc_o(div0_exc_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    valid_i = 1'b1; alu_ctrl_i = code; rs_i = a; rt_i = b;
    tick();
    valid_i = 1'b0;
    n = 0;
    while (!done_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32);
    chk({tag, "_busy_fin"}, {31'd0, busy_o}, 1);
    tick();
    chk({tag, "_busy_after"}, {31'd0, busy_o}, 0);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    int n;
    logic saw_done;
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alu_ctrl_i = 6'd0; rs_i = '0; rt_i = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_stall", {31'd0, stall_o}, 0);

    run_op("multu_max", 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  6'd24, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("divu_100_7", 6'd27, 32'd100,     32'd7,        32'd2,        32'd14);
    run_op("div_m7_2",  6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",   6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // mthi / mtlo while idle, then read back
    valid_i = 1'b1; alu_ctrl_i = 6'd17; rs_i = 32'h12345678; #1;
    chk("mthi_stall", {31'd0, stall_o}, 0);
    tick();
    alu_ctrl_i = 6'd19; rs_i = 32'h9ABCDEF0; #1;
    chk("mtlo_stall", {31'd0, stall_o}, 0);
    tick();
    alu_ctrl_i = 6'd16; #1;
    chk("mfhi_rd", hilo_rd_o, 32'h12345678);
    alu_ctrl_i = 6'd18; #1;
    chk("mflo_rd", hilo_rd_o, 32'h9ABCDEF0);
    valid_i = 1'b0;

    // mflo one cycle after a mult start stays stalled through FIN
    valid_i = 1'b1; alu_ctrl_i = 6'd24; rs_i = 32'd6; rt_i = 32'd7;
    tick();
    alu_ctrl_i = 6'd18; #1;
    n = 0; saw_done = 1'b0;
    while (stall_o && n < 50) begin
      if (done_o) saw_done = 1'b1;
      tick();
      n++;
    end
    chk("mflo_stall_cycles", n, 33);
    chk("mflo_saw_done", {31'd0, saw_done}, 1);
    chk("mflo_released_rd", hilo_rd_o, 32'd42);
    chk("mflo_busy_after", {31'd0, busy_o}, 0);
    valid_i = 1'b0;

    // flush in RUN cycle 10 of a div
    valid_i = 1'b1; alu_ctrl_i = 6'd17; rs_i = 32'hAAAA0000; tick();
    alu_ctrl_i = 6'd19; rs_i = 32'h0000BBBB; tick();
    alu_ctrl_i = 6'd26; rs_i = 32'd100; rt_i = 32'd7;
    tick();
    alu_ctrl_i = 6'd25; #1;
    chk("collide_stall", {31'd0, stall_o}, 1);
    valid_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1; #1;
    chk("flush_busy_before", {31'd0, busy_o}, 1);
    tick();
    flush_i = 1'b0;
    chk("flush_busy_after", {31'd0, busy_o}, 0);
    saw_done = 1'b0;
    repeat (40) begin
      if (done_o) saw_done = 1'b1;
      tick();
    end
    chk("flush_no_done", {31'd0, saw_done}, 0);
    chk("flush_hi_kept", hi_o, 32'hAAAA0000);
    chk("flush_lo_kept", lo_o, 32'h0000BBBB);
    run_op("multu_after_flush", 6'd25, 32'd3, 32'd4, 32'd0, 32'd12);

`ifdef MULDIV_DIV0_EXC_EN
    valid_i = 1'b1; alu_ctrl_i = 6'd27; rs_i = 32'd1234; rt_i = 32'd0;
    tick();
    valid_i = 1'b0;
    chk("div0_exc_pulse", {31'd0, div0_exc_o}, 1);
    chk("div0_busy", {31'd0, busy_o}, 0);
    tick();
    chk("div0_exc_clear", {31'd0, div0_exc_o}, 0);
    chk("div0_hi_kept", hi_o, 32'd0);
    chk("div0_lo_kept", lo_o, 32'd12);
`else
    run_op("divu_by0", 6'd27, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
